// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine: mode encoding, kernel coefficients, accumulator sizing.
// Latency: none (declarations only).
// Backpressure: not applicable. Optional saturation counter in the top is enabled by CONV_SAT_COUNT_EN.
package conv_pkg;

    typedef enum logic [2:0] {
        CONV_CLEAR = 3'd0,
        CONV_SOBX  = 3'd1,
        CONV_SOBY  = 3'd2,
        CONV_GAUSS = 3'd3,
        CONV_MAG   = 3'd4
    } conv_mode_e;

    // Coefficients indexed k = row*3 + col, row 0 on top, col 0 on the left.
    localparam int SOBX_K  [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int SOBY_K  [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    localparam int GAUSS_K [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    // Worst case is the Gaussian (weight total 16) plus a sign bit, with one bit of headroom.
    function automatic int conv_sum_w(input int pix_w);
        return pix_w + 6;
    endfunction

endpackage

// File: rtl/conv_postproc.sv
// Final-stage arithmetic: absolute value, magnitude add, Gaussian round-shift, clip and clip flag.
// Latency: purely combinational; the result register lives in the caller.
// Backpressure: none here; the caller decides when the result is captured.
module conv_postproc
    import conv_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int SUM_W = conv_sum_w(PIX_W)
) (
    input  logic [2:0]              mode,
    input  logic signed [SUM_W-1:0] sum_a,
    input  logic signed [SUM_W-1:0] sum_b,
    output logic [PIX_W-1:0]        pix,
    output logic                    sat
);

    localparam logic [SUM_W:0] MAX_V = (SUM_W+1)'((1 << PIX_W) - 1);

    logic [SUM_W-1:0]        abs_a;
    logic [SUM_W-1:0]        abs_b;
    logic signed [SUM_W-1:0] rnd;
    logic [SUM_W-1:0]        gsh;
    logic [SUM_W:0]          val;

    // Pick the pre-clip value for the mode, then clip to the pixel range.
    // The Gaussian result is at most 16*max/16 after rounding, so it never clips.
    always_comb begin
        abs_a = sum_a[SUM_W-1] ? -sum_a : sum_a;
        abs_b = sum_b[SUM_W-1] ? -sum_b : sum_b;
        rnd   = sum_a + $signed(SUM_W'(8));
        gsh   = rnd >>> 4;
        case (mode)
            CONV_SOBX, CONV_SOBY: val = {1'b0, abs_a};
            CONV_GAUSS:           val = {1'b0, gsh};
            CONV_MAG:             val = {1'b0, abs_a} + {1'b0, abs_b};
            default:              val = '0;
        endcase
        sat = (val > MAX_V);
        pix = sat ? MAX_V[PIX_W-1:0] : val[PIX_W-1:0];
    end

endmodule

// File: rtl/convolve_pipe.sv
// 3x3 convolution engine (clear, Sobel X/Y, Gaussian, Sobel magnitude), one window in and one pixel out per cycle.
// Latency: 3 register stages (row sums, full sums, post-processed output).
// Backpressure: all stages advance together only when ena is high and the output slot is empty or being taken; CONV_SAT_COUNT_EN adds sat_count.
module convolve_pipe
    import conv_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int SUM_W = conv_sum_w(PIX_W)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9*PIX_W-1:0] in_win,
    input  logic [2:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_pix,
    output logic               out_sat
`ifdef CONV_SAT_COUNT_EN
    ,
    output logic [15:0]        sat_count
`endif
);

    logic adv;

    assign adv      = ena & (~out_valid | out_ready);
    assign in_ready = adv;

    // Coefficients are small constants, so each product reduces to a shift and optional negate.
    function automatic logic signed [SUM_W-1:0] wmul(input logic [PIX_W-1:0] p, input int c);
        logic signed [SUM_W-1:0] x;
        x = $signed({{(SUM_W-PIX_W){1'b0}}, p});
        case (c)
            1:       return x;
            2:       return x <<< 1;
            4:       return x <<< 2;
            -1:      return -x;
            -2:      return -(x <<< 1);
            default: return '0;
        endcase
    endfunction

    logic signed [SUM_W-1:0] row_x [3];
    logic signed [SUM_W-1:0] row_y [3];
    logic signed [SUM_W-1:0] row_g [3];
    logic signed [SUM_W-1:0] row_a [3];

    // Per-row weighted sums for every kernel; kernel A follows the mode, Sobel X in magnitude mode.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_x[r] = '0;
            row_y[r] = '0;
            row_g[r] = '0;
            for (int c = 0; c < 3; c++) begin
                row_x[r] = row_x[r] + wmul(in_win[(r*3+c)*PIX_W +: PIX_W], SOBX_K[r*3+c]);
                row_y[r] = row_y[r] + wmul(in_win[(r*3+c)*PIX_W +: PIX_W], SOBY_K[r*3+c]);
                row_g[r] = row_g[r] + wmul(in_win[(r*3+c)*PIX_W +: PIX_W], GAUSS_K[r*3+c]);
            end
            case (in_mode)
                CONV_SOBX, CONV_MAG: row_a[r] = row_x[r];
                CONV_SOBY:           row_a[r] = row_y[r];
                CONV_GAUSS:          row_a[r] = row_g[r];
                default:             row_a[r] = '0;
            endcase
        end
    end

    logic                    s1_vld;
    logic [2:0]              s1_mode;
    logic signed [SUM_W-1:0] s1_a [3];
    logic signed [SUM_W-1:0] s1_b [3];

    // Stage 1: capture row sums and the mode that travels with this beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_vld  <= 1'b0;
            s1_mode <= '0;
            for (int r = 0; r < 3; r++) begin
                s1_a[r] <= '0;
                s1_b[r] <= '0;
            end
        end else if (adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                for (int r = 0; r < 3; r++) begin
                    s1_a[r] <= row_a[r];
                    s1_b[r] <= row_y[r];
                end
            end
        end
    end

    logic                    s2_vld;
    logic [2:0]              s2_mode;
    logic signed [SUM_W-1:0] s2_a;
    logic signed [SUM_W-1:0] s2_b;

    // Stage 2: fold the three rows into full signed sums.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_vld  <= 1'b0;
            s2_mode <= '0;
            s2_a    <= '0;
            s2_b    <= '0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_mode <= s1_mode;
                s2_a    <= s1_a[0] + s1_a[1] + s1_a[2];
                s2_b    <= s1_b[0] + s1_b[1] + s1_b[2];
            end
        end
    end

    logic [PIX_W-1:0] pp_pix;
    logic             pp_sat;

    conv_postproc #(
        .PIX_W (PIX_W),
        .SUM_W (SUM_W)
    ) u_postproc (
        .mode  (s2_mode),
        .sum_a (s2_a),
        .sum_b (s2_b),
        .pix   (pp_pix),
        .sat   (pp_sat)
    );

    // Stage 3: output register; it only moves on adv so a stalled result stays put.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_pix <= pp_pix;
                out_sat <= pp_sat;
            end
        end
    end

`ifdef CONV_SAT_COUNT_EN
    // Count clipped results as they leave the engine (only when the pipe really advances), sticking at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && ena && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_convolve_pipe.sv
// Self-checking bench for convolve_pipe: directed kernel cases, reset mid-stream, random streams with backpressure.
// Expected pixels come from an integer model of the kernels kept in this file.
// Optional sat_count checks compile in when CONV_SAT_COUNT_EN is defined.
module tb_convolve_pipe;

    localparam int PW   = 8;
    localparam int MAXP = 255;

    logic            clk = 1'b0;
    logic            resetn;
    logic            ena;
    logic            in_valid;
    logic            in_ready;
    logic [9*PW-1:0] in_win;
    logic [2:0]      in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   out_pix;
    logic            out_sat;
`ifdef CONV_SAT_COUNT_EN
    logic [15:0]     sat_count;
`endif

    typedef struct {
        int pix;
        bit sat;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    int   last_pix;
    int   last_sat;
    int   n_pop = 0;
    int   cyc = 0;
    int   sat_model = 0;

    always #5 clk = ~clk;

    convolve_pipe #(.PIX_W(PW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_win    (in_win),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_sat   (out_sat)
`ifdef CONV_SAT_COUNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: plain integer convolution straight from the kernel definitions.
    function automatic res_t ref_conv(input logic [9*PW-1:0] w, input logic [2:0] m);
        int   p [9];
        int   gx, gy, g, v;
        res_t r;
        for (int k = 0; k < 9; k++) p[k] = int'(w[k*PW +: PW]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        g  = p[0] + p[2] + p[6] + p[8] + 2*(p[1] + p[3] + p[5] + p[7]) + 4*p[4];
        case (m)
            3'd1:    v = iabs(gx);
            3'd2:    v = iabs(gy);
            3'd3:    v = (g + 8) / 16;
            3'd4:    v = iabs(gx) + iabs(gy);
            default: v = 0;
        endcase
        r.sat = (v > MAXP);
        r.pix = r.sat ? MAXP : v;
        return r;
    endfunction

    function automatic logic [9*PW-1:0] by_cols(input int l, input int m, input int r);
        logic [9*PW-1:0] w;
        for (int row = 0; row < 3; row++) begin
            w[(row*3+0)*PW +: PW] = PW'(l);
            w[(row*3+1)*PW +: PW] = PW'(m);
            w[(row*3+2)*PW +: PW] = PW'(r);
        end
        return w;
    endfunction

    function automatic logic [9*PW-1:0] by_rows(input int t, input int m, input int b);
        logic [9*PW-1:0] w;
        for (int col = 0; col < 3; col++) begin
            w[(0*3+col)*PW +: PW] = PW'(t);
            w[(1*3+col)*PW +: PW] = PW'(m);
            w[(2*3+col)*PW +: PW] = PW'(b);
        end
        return w;
    endfunction

    function automatic logic [9*PW-1:0] rand_win();
        logic [9*PW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'($urandom_range(0, MAXP));
        return w;
    endfunction

    // One clock: check handshake rules, score any output transfer, record any input transfer.
    task automatic step(output bit accepted);
        bit            pop;
        bit            hold;
        logic [PW-1:0] hp;
        logic          hs;
        res_t          e;
        #1;
        accepted = in_valid & in_ready;
        pop      = out_valid & out_ready & ena;
        chk("in_ready", in_ready, ena & (~out_valid | out_ready));
        if (pop) begin
            n_pop++;
            last_pix = out_pix;
            last_sat = out_sat;
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_pix", out_pix, e.pix);
                chk("out_sat", out_sat, e.sat);
                if (e.sat && sat_model != 32'hFFFF) sat_model++;
            end
        end
        if (accepted) exp_q.push_back(ref_conv(in_win, in_mode));
        hold = out_valid & ~pop;
        hp   = out_pix;
        hs   = out_sat;
        @(posedge clk);
        #1;
        cyc++;
        if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_pix", out_pix, hp);
            chk("hold_sat", out_sat, hs);
        end
    endtask

    task automatic send(input logic [9*PW-1:0] w, input logic [2:0] m);
        int n;
        bit done;
        n        = 0;
        done     = 0;
        last_pix = -1;
        in_win   = w;
        in_mode  = m;
        in_valid = 1'b1;
        while (!done && n < 50) begin
            step(done);
            n++;
        end
        in_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic drain();
        int n;
        bit d;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            step(d);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit              acc;
        int              n;
        int              idx;
        int              c0;
        logic [9*PW-1:0] w;

        resetn    = 1'b1;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_win    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #1 resetn = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_out_sat", out_sat, 0);
`ifdef CONV_SAT_COUNT_EN
        chk("rst_sat_count", sat_count, 0);
`endif
        @(posedge clk);
        #1 resetn = 1'b1;

        // Directed kernel cases.
        send(by_cols(10, 10, 10), 3'd1);   drain();
        chk("sobx_flat_pix", last_pix, 0);   chk("sobx_flat_sat", last_sat, 0);
        send(by_cols(0, 0, 200), 3'd1);    drain();
        chk("sobx_edge_pix", last_pix, 255); chk("sobx_edge_sat", last_sat, 1);
        send(by_cols(40, 50, 60), 3'd1);   drain();
        chk("sobx_soft_pix", last_pix, 80);  chk("sobx_soft_sat", last_sat, 0);
        send(by_cols(100, 100, 100), 3'd3); drain();
        chk("gauss_flat_pix", last_pix, 100);
        w = by_rows(0, 0, 0);
        w[4*PW +: PW] = 8'd255;
        send(w, 3'd3);                     drain();
        chk("gauss_centre_pix", last_pix, 64); chk("gauss_centre_sat", last_sat, 0);
        send(by_rows(0, 15, 30), 3'd4);    drain();
        chk("mag_pix", last_pix, 120);       chk("mag_sat", last_sat, 0);
        send(by_cols(0, 0, 200), 3'd6);    drain();
        chk("reserved_pix", last_pix, 0);    chk("reserved_sat", last_sat, 0);

        // Reset mid-stream with three beats in flight.
        for (int i = 0; i < 3; i++) send(rand_win(), 3'd1);
        chk("pre_reset_valid", out_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_pix", out_pix, 0);
        chk("midrst_out_sat", out_sat, 0);
        exp_q.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            chk("post_reset_idle", out_valid, 0);
        end

        // Latency: beat presented in cycle 0 is visible in cycle 3.
        in_win   = rand_win();
        in_mode  = 3'd3;
        in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        chk("lat_accept", acc, 1);
        n = 1;
        while (!out_valid && n < 10) begin
            step(acc);
            n++;
        end
        chk("latency", n, 3);
        drain();

        // Random back-to-back stream at full rate, all modes including reserved.
        c0 = cyc;
        for (int i = 0; i < 40; i++) send(rand_win(), 3'($urandom_range(0, 7)));
        chk("throughput", cyc - c0, 40);
        drain();

        // Backpressure: 10 beats, random out_ready, ena low for 5 cycles.
        n_pop   = 0;
        idx     = 0;
        n       = 0;
        in_win  = rand_win();
        in_mode = 3'd1;
        while ((idx < 10 || exp_q.size() != 0) && n < 300) begin
            in_valid  = (idx < 10);
            out_ready = 1'($urandom_range(0, 1));
            ena       = !(n >= 8 && n < 13);
            step(acc);
            if (acc) begin
                idx++;
                in_win  = rand_win();
                in_mode = 3'((idx % 4) + 1);
            end
            n++;
        end
        in_valid  = 1'b0;
        ena       = 1'b1;
        out_ready = 1'b1;
        drain();
        chk("bp_accepted", idx, 10);
        chk("bp_emitted", n_pop, 10);

`ifdef CONV_SAT_COUNT_EN
        resetn = 1'b0;
        #1;
        chk("satcnt_cleared", sat_count, 0);
        sat_model = 0;
        exp_q.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        out_ready = 1'b0;
        send(by_cols(0, 0, 200), 3'd1);
        n = 0;
        while (!out_valid && n < 10) begin
            step(acc);
            n++;
        end
        chk("sat_hold_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) step(acc);
        chk("satcnt_held", sat_count, 0);
        out_ready = 1'b1;
        step(acc);
        chk("satcnt_once", sat_count, 1);
        for (int i = 0; i < 3; i++) step(acc);
        chk("satcnt_still_once", sat_count, sat_model);
        for (int i = 0; i < 70000; i++) send(by_cols(0, 0, 200), 3'd1);
        drain();
        chk("satcnt_stick", sat_count, 16'hFFFF);
        chk("satcnt_model", sat_count, sat_model);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
